// File: rtl/stream_demux_1ton.sv
// stream_demux_1ton: 1-to-N valid/ready demux with per-channel holding slot, broadcast and counted drops
module stream_demux_1ton #(
  parameter int N_OUT = 8,
  parameter int SEL_W = 3,
  parameter int DW    = 8,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DW-1:0]       in_data,
  input  logic [SEL_W-1:0]    in_sel,
  input  logic                in_bcast,
  output logic [N_OUT-1:0]    out_valid,
  input  logic [N_OUT-1:0]    out_ready,
  output logic [N_OUT*DW-1:0] out_data,
  output logic                err_drop,
  output logic [CNT_W-1:0]    drop_cnt
);
  localparam logic [SEL_W:0] NL = (SEL_W+1)'(N_OUT);
  logic [N_OUT-1:0]      free, wr;
  logic [2**SEL_W-1:0]   free_p;
  logic                  sel_ok, accept, drop;
  assign sel_ok   = {1'b0, in_sel} < NL;
  // invalid selects index the padding, which reads as free so those beats are always sunk
  assign in_ready = in_bcast ? &free : free_p[in_sel];
  assign accept   = in_valid & in_ready;
  assign drop     = accept & ~in_bcast & ~sel_ok;
  // slot availability and per-channel write strobes
  always_comb begin
    free   = ~out_valid | out_ready;
    free_p = '1;
    free_p[N_OUT-1:0] = free;
    wr = '0;
    for (int i = 0; i < N_OUT; i++)
      wr[i] = accept & (in_bcast | (in_sel == SEL_W'(i)));
  end
  // holding slots: load on write, otherwise clear valid once the consumer takes the beat
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= '0;
      out_data  <= '0;
    end else begin
      for (int i = 0; i < N_OUT; i++)
        if (wr[i]) begin
          out_valid[i]         <= 1'b1;
          out_data[i*DW +: DW] <= in_data;
        end else if (out_ready[i]) begin
          out_valid[i] <= 1'b0;
        end
    end
  // drop pulse and saturating drop counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      err_drop <= 1'b0;
      drop_cnt <= '0;
    end else begin
      err_drop <= drop;
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_stream_demux_1ton.sv
// tb_stream_demux_1ton: randomized scoreboard bench for stream_demux_1ton
module tb_stream_demux_1ton;
  localparam int N = 6, SW = 3, DW = 8, CW = 3;
  localparam int CMAX = (1 << CW) - 1;
  logic            clk = 1'b0, rst_n = 1'b1;
  logic            in_valid, in_ready, in_bcast, err_drop;
  logic [DW-1:0]   in_data;
  logic [SW-1:0]   in_sel;
  logic [N-1:0]    out_valid, out_ready;
  logic [N*DW-1:0] out_data;
  logic [CW-1:0]   drop_cnt;
  int checks = 0, errors = 0;
  int q[N][$];
  int exp_cnt = 0;
  bit exp_err = 0, run = 0;
  bit pend_acc = 0, pend_bcast;
  int pend_sel, pend_data;

  stream_demux_1ton #(.N_OUT(N), .SEL_W(SW), .DW(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .err_drop(err_drop), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // model: commit the beat accepted in the previous cycle to the expected slot contents
  task automatic apply_pending();
    exp_err = pend_acc && !pend_bcast && pend_sel >= N;
    if (exp_err && exp_cnt < CMAX) exp_cnt++;
    if (pend_acc && pend_bcast) for (int k = 0; k < N; k++) q[k].push_back(pend_data);
    else if (pend_acc && pend_sel < N) q[pend_sel].push_back(pend_data);
    pend_acc = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_drop_cnt"}, int'(drop_cnt), 0);
    chk({tag, "_err_drop"}, int'(err_drop), 0);
  endtask

  task automatic clear_model();
    for (int k = 0; k < N; k++) q[k].delete();
    exp_cnt = 0;
    exp_err = 0;
    pend_acc = 0;
  endtask

  // monitor: compare presented outputs against the scoreboard, retire beats on handshake
  initial forever begin
    @(negedge clk);
    if (rst_n && run) begin
      for (int k = 0; k < N; k++) begin
        bit ev;
        ev = q[k].size() != 0;
        chk($sformatf("out_valid[%0d]", k), int'(out_valid[k]), int'(ev));
        if (ev && out_valid[k]) chk($sformatf("out_data[%0d]", k), int'(out_data[k*DW +: DW]), q[k][0]);
        if (ev && out_ready[k]) void'(q[k].pop_front());
      end
      chk("err_drop", int'(err_drop), int'(exp_err));
      chk("drop_cnt", int'(drop_cnt), exp_cnt);
    end
  end

  // driver: random stimulus, model in_ready, record accepted beat
  initial begin
    in_valid = 0; in_bcast = 0; in_sel = '0; in_data = '0; out_ready = '0;
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("init");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run = 1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit all_free, exp_rdy;
      bit [N-1:0] fr;
      @(posedge clk);
      apply_pending();
      #1;
      if (cyc == 1500) begin
        in_valid = 0;
        rst_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        clear_model();
        @(posedge clk);
        #3 rst_n = 1'b1;
        continue;
      end
      in_valid = $urandom_range(0, 3) != 0;
      in_bcast = $urandom_range(0, 5) == 0;
      in_sel   = SW'($urandom_range(0, 7));
      in_data  = DW'($urandom);
      for (int k = 0; k < N; k++)
        out_ready[k] = (cyc % 400 < 80) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) < 7);
      #1;
      all_free = 1;
      for (int k = 0; k < N; k++) begin
        fr[k] = q[k].size() == 0 || out_ready[k];
        all_free &= fr[k];
      end
      exp_rdy = in_bcast ? all_free : (int'(in_sel) < N ? fr[in_sel] : 1'b1);
      chk("in_ready", int'(in_ready), int'(exp_rdy));
      pend_acc   = in_valid && exp_rdy;
      pend_bcast = in_bcast;
      pend_sel   = int'(in_sel);
      pend_data  = int'(in_data);
    end
    @(posedge clk);
    apply_pending();
    #1;
    in_valid = 0;
    out_ready = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
